// File: rtl/y86_shell_pkg.sv
// Shared constants, receiver state type and the Set-2 scancode to ASCII table
// for the Y86 keyboard/TTY shell.
package y86_shell_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_BS    = 7'h08;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  typedef struct packed {
    logic       vld;
    logic [6:0] ch;
  } dec_t;

  // upper selects letter case only; shift selects the digit-row symbols
  function automatic dec_t sc_decode(input logic [7:0] code, input logic upper,
                                     input logic shift);
    dec_t d;
    d.vld = 1'b1;
    d.ch  = 7'h00;
    case (code)
      8'h1C: d.ch = 7'h61;  8'h32: d.ch = 7'h62;  8'h21: d.ch = 7'h63;
      8'h23: d.ch = 7'h64;  8'h24: d.ch = 7'h65;  8'h2B: d.ch = 7'h66;
      8'h34: d.ch = 7'h67;  8'h33: d.ch = 7'h68;  8'h43: d.ch = 7'h69;
      8'h3B: d.ch = 7'h6A;  8'h42: d.ch = 7'h6B;  8'h4B: d.ch = 7'h6C;
      8'h3A: d.ch = 7'h6D;  8'h31: d.ch = 7'h6E;  8'h44: d.ch = 7'h6F;
      8'h4D: d.ch = 7'h70;  8'h15: d.ch = 7'h71;  8'h2D: d.ch = 7'h72;
      8'h1B: d.ch = 7'h73;  8'h2C: d.ch = 7'h74;  8'h3C: d.ch = 7'h75;
      8'h2A: d.ch = 7'h76;  8'h1D: d.ch = 7'h77;  8'h22: d.ch = 7'h78;
      8'h35: d.ch = 7'h79;  8'h1A: d.ch = 7'h7A;
      8'h45: d.ch = shift ? 7'h29 : 7'h30;
      8'h16: d.ch = shift ? 7'h21 : 7'h31;
      8'h1E: d.ch = shift ? 7'h40 : 7'h32;
      8'h26: d.ch = shift ? 7'h23 : 7'h33;
      8'h25: d.ch = shift ? 7'h24 : 7'h34;
      8'h2E: d.ch = shift ? 7'h25 : 7'h35;
      8'h36: d.ch = shift ? 7'h5E : 7'h36;
      8'h3D: d.ch = shift ? 7'h26 : 7'h37;
      8'h3E: d.ch = shift ? 7'h2A : 7'h38;
      8'h46: d.ch = shift ? 7'h28 : 7'h39;
      8'h29: d.ch = ASCII_SPACE;
      8'h5A: d.ch = ASCII_CR;
      8'h66: d.ch = ASCII_BS;
      default: d.vld = 1'b0;
    endcase
    if (upper && d.ch >= 7'h61 && d.ch <= 7'h7A) d.ch = d.ch - 7'h20;
    return d;
  endfunction

endpackage

// File: rtl/y86_kb_tty_shell_ps2_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, start/data/
// parity/stop FSM with odd-parity check and a mid-frame inactivity timeout.
import y86_shell_pkg::*;

module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_q, clk_s, dat_s, fall;
  rx_state_t              state;
  logic [2:0]             cnt;
  logic [7:0]             shreg;
  logic                   par_ok;
  logic [TW-1:0]          tmo;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_q & ~clk_s;

  // lines idle high, so the synchronisers reset to 1 to avoid a false fall
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_q    <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      tmo      <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || fall) tmo <= '0;
      else                       tmo <= tmo + 1'b1;
      if (state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: if (!dat_s) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: begin
            shreg <= {dat_s, shreg[7:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, dat_s};
            state  <= STOP;
          end
          STOP: begin
            if (par_ok && dat_s) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/y86_kb_tty_shell.sv
// Y86 board keyboard/TTY shell: scancode decoder, char FIFO and TTY writer.
// Optional feature: define CAPS_LOCK_EN to enable the caps-lock toggle.
import y86_shell_pkg::*;

module y86_kb_tty_shell #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       ps2_in,
  input  logic       ps2_clk,
  input  logic       TTY_ready,
  output logic [6:0] TTY_data,
  output logic       TTY_en,
  output logic       TTY_clear
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk     (mclk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_in),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  logic brk, ext, shift, caps, clr_pend;
  logic esc, push, push_ok, pop, full, empty;
  dec_t dec;

  assign dec  = sc_decode(rx_byte, shift ^ caps, shift);
  assign push = rx_valid && !brk && !ext && dec.vld;
  assign esc  = rx_valid && !brk && !ext && rx_byte == SC_ESC;

  always_ff @(posedge mclk) begin
    if (reset) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      shift     <= 1'b0;
      clr_pend  <= 1'b1;
      TTY_clear <= 1'b0;
    end else begin
      TTY_clear <= clr_pend | esc;
      clr_pend  <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == SC_BREAK)     brk <= 1'b1;
        else if (rx_byte == SC_EXT)  ext <= 1'b1;
        else begin
          // any non-prefix code consumes the pending prefixes
          brk <= 1'b0;
          ext <= 1'b0;
          if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) shift <= ~brk;
        end
      end
    end
  end

`ifdef CAPS_LOCK_EN
  always_ff @(posedge mclk) begin
    if (reset) caps <= 1'b0;
    else if (rx_valid && !brk && !ext && rx_byte == SC_CAPS) caps <= ~caps;
  end
`else
  assign caps = 1'b0;
`endif

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop     = !empty && TTY_ready && !TTY_en;

  always_ff @(posedge mclk) begin
    if (push_ok) mem[wr_ptr] <= dec.ch;
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      TTY_en   <= 1'b0;
      TTY_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      // gating on TTY_en keeps strobes at least one idle cycle apart
      TTY_en <= pop;
      if (pop) begin
        TTY_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_y86_kb_tty_shell.sv
// Directed bench for y86_kb_tty_shell: PS/2 frames in, TTY strobes checked.
`timescale 1ns/1ps
module tb_y86_kb_tty_shell;
  localparam int H   = 20;   // half PS/2 bit period in mclk cycles
  localparam int TMO = 400;

  logic       mclk = 1'b0;
  logic       reset, ps2_in, ps2_clk, TTY_ready;
  logic [6:0] TTY_data;
  logic       TTY_en, TTY_clear;
  int checks = 0, errors = 0;

  always #6.25 mclk = ~mclk;

  y86_kb_tty_shell #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .mclk(mclk), .reset(reset), .ps2_in(ps2_in), .ps2_clk(ps2_clk),
    .TTY_ready(TTY_ready), .TTY_data(TTY_data), .TTY_en(TTY_en), .TTY_clear(TTY_clear)
  );

  int         cyc = 0, clr_cnt = 0, b2b = 0;
  logic       en_prev = 1'b0;
  logic [6:0] outq[$];
  int         en_cyc[$];

  always @(posedge mclk) cyc <= cyc + 1;

  always @(negedge mclk) begin
    if (TTY_en === 1'b1) begin
      outq.push_back(TTY_data);
      en_cyc.push_back(cyc);
      if (en_prev) b2b++;
    end
    en_prev = (TTY_en === 1'b1);
    if (TTY_clear === 1'b1) clr_cnt++;
  end

  int rd = 0, fall_cyc = 0, base = 0, lat = 0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send_bit(logic b);
    ps2_in = b;
    cyc_wait(H);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    cyc_wait(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] code, logic bad_par = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    send_bit(1'b1);
    ps2_in = 1'b1;
    cyc_wait(H);
  endtask

  task automatic expect_chars(string tag, int n, logic [6:0] c0 = 0, logic [6:0] c1 = 0,
                              logic [6:0] c2 = 0, logic [6:0] c3 = 0);
    logic [6:0] exp[4];
    exp = '{c0, c1, c2, c3};
    chk({tag, "_cnt"}, outq.size() - rd, n);
    for (int i = 0; i < n && i < 4; i++) begin
      if (rd < outq.size()) begin
        chk({tag, "_ch"}, int'(outq[rd]), int'(exp[i]));
        rd++;
      end
    end
    rd = outq.size();
  endtask

  initial begin
    #750000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ps2_in = 1'b1; ps2_clk = 1'b1; TTY_ready = 1'b1;
    cyc_wait(3);
    chk("rst_en", int'(TTY_en), 0);
    chk("rst_clear", int'(TTY_clear), 0);
    chk("rst_data", int'(TTY_data), 0);
    base = clr_cnt;
    reset = 1'b0;
    cyc_wait(10);
    chk("post_rst_clear", clr_cnt - base, 1);
    expect_chars("post_rst", 0);

    // 1: plain 'h' plus stop-fall to strobe latency
    send_frame(8'h33);
    lat = (en_cyc.size() > 0) ? en_cyc[en_cyc.size()-1] - fall_cyc : 999;
    expect_chars("t1", 1, 7'h68);
    chk("t1_latency_ok", int'(lat >= 0 && lat <= 6), 1);

    // 2: shift held
    send_frame(8'h12); send_frame(8'h33);
    expect_chars("t2", 1, 7'h48);

    // 3: shift pressed then released
    send_frame(8'h12); send_frame(8'hF0); send_frame(8'h12); send_frame(8'h33);
    expect_chars("t3", 1, 7'h68);

    // 4: bad parity dropped, next frame fine
    send_frame(8'h33, 1'b1);
    expect_chars("t4_badpar", 0);
    send_frame(8'h1C);
    expect_chars("t4", 1, 7'h61);

    // 5: writer stalled, then drains in order with gaps
    TTY_ready = 1'b0;
    send_frame(8'h33); send_frame(8'h32); send_frame(8'h21);
    expect_chars("t5_stall", 0);
    base = b2b;
    TTY_ready = 1'b1;
    cyc_wait(20);
    expect_chars("t5", 3, 7'h68, 7'h62, 7'h63);
    chk("t5_b2b", b2b - base, 0);

    // 6: fifo full drops the fifth char
    TTY_ready = 1'b0;
    send_frame(8'h1C); send_frame(8'h32); send_frame(8'h21); send_frame(8'h23); send_frame(8'h24);
    expect_chars("t6_stall", 0);
    TTY_ready = 1'b1;
    cyc_wait(20);
    expect_chars("t6", 4, 7'h61, 7'h62, 7'h63, 7'h64);

    // 7: shifted digit, digit, space, unmapped, ext-prefixed, letter
    send_frame(8'h12); send_frame(8'h16);
    send_frame(8'hF0); send_frame(8'h12);
    send_frame(8'h45); send_frame(8'h29); send_frame(8'h0E);
    send_frame(8'hE0); send_frame(8'h1C); send_frame(8'h1C);
    expect_chars("t7", 4, 7'h21, 7'h30, 7'h20, 7'h61);

    // 8: stalled partial frame times out, next frame decodes cleanly
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2_in = 1'b1;
    cyc_wait(TMO + 50);
    send_frame(8'h1C);
    expect_chars("t8", 1, 7'h61);

    // 9: reset after the 4th data bit discards the frame; Esc clears
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    base = clr_cnt;
    reset = 1'b1;
    cyc_wait(3);
    reset = 1'b0;
    ps2_in = 1'b1;
    cyc_wait(10 * H);
    chk("t9_rst_clear", clr_cnt - base, 1);
    expect_chars("t9_rst", 0);
    base = clr_cnt;
    send_frame(8'h76);
    chk("t9_esc_clear", clr_cnt - base, 1);
    expect_chars("t9_esc", 0);

    // 10: 0x58 is caps lock only when the feature is built in
    send_frame(8'h58); send_frame(8'h33);
`ifdef CAPS_LOCK_EN
    expect_chars("t10", 1, 7'h48);
`else
    expect_chars("t10", 1, 7'h68);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
